// File: rtl/cic_lia_pkg.sv
// Shared definitions for the CIC lock-in decimator sequencer.
package cic_lia_pkg;

  localparam int STATE_W    = 2;
  localparam int DATA_W_DEF = 14;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry valid/ready holding register. A load while the held word is still
// waiting is rejected and flagged as a drop; the held word is never overwritten.
module stream_hold_reg
  import cic_lia_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] s_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              drop
);

  logic [DATA_W-1:0] data_r;
  logic              valid_r;

  assign data  = data_r;
  assign valid = valid_r;
  assign drop  = load && valid_r && !ready;

  // Holding register: clear wins, then load when the slot is free or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load && (!valid_r || ready)) begin
      data_r  <= s_data;
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/cic_lia_sequencer.sv
// Sequences one CIC decimator: owns its reset, discards the start-up transient
// and presents settled samples as a valid/ready stream with a drop counter.
module cic_lia_sequencer
  import cic_lia_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int N_STAGES     = 2,
  parameter int SETTLE_EXTRA = 1,
  parameter int RST_CYCLES   = 4,
  parameter int DROP_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               restart,
  output logic               cic_rst,
  input  logic               cic_dclk,
  input  logic [DATA_W-1:0]  cic_data,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               locked,
  output logic [STATE_W-1:0] state,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int SETTLE_N = N_STAGES + SETTLE_EXTRA;
  localparam int CNT_MAX  = (RST_CYCLES > SETTLE_N) ? RST_CYCLES : SETTLE_N;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  seq_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              stb_d_r;
  logic              cic_rst_r;
  logic              locked_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic load_s;
  logic clear_s;
  logic drop_s;

  // A sample aborted by restart or enable fall is discarded, never loaded.
  assign load_s  = (state_r == ST_RUN) && stb_d_r && enable && !restart;
  assign clear_s = (state_r == ST_IDLE) ? enable : (!enable || restart);

  assign cic_rst  = cic_rst_r;
  assign locked   = locked_r;
  assign state    = state_r;
  assign drop_cnt = drop_cnt_r;

  stream_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .load   (load_s),
    .s_data (cic_data),
    .ready  (m_ready),
    .data   (m_data),
    .valid  (m_valid),
    .drop   (drop_s)
  );

  // Sequencer FSM with strobe delay, phase counter and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      stb_d_r    <= 1'b0;
      cic_rst_r  <= 1'b1;
      locked_r   <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      stb_d_r <= cic_dclk;
      if (state_r == ST_IDLE) begin
        cic_rst_r <= 1'b1;
        locked_r  <= 1'b0;
        if (enable) begin
          state_r    <= ST_RESET;
          cnt_r      <= {CNT_W{1'b0}};
          stb_d_r    <= 1'b0;
          drop_cnt_r <= {DROP_W{1'b0}};
        end
      end else if (!enable) begin
        state_r   <= ST_IDLE;
        cnt_r     <= {CNT_W{1'b0}};
        cic_rst_r <= 1'b1;
        locked_r  <= 1'b0;
      end else if (restart) begin
        state_r    <= ST_RESET;
        cnt_r      <= {CNT_W{1'b0}};
        stb_d_r    <= 1'b0;
        cic_rst_r  <= 1'b1;
        locked_r   <= 1'b0;
        drop_cnt_r <= {DROP_W{1'b0}};
      end else begin
        case (state_r)
          ST_RESET: begin
            if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
              state_r   <= ST_SETTLE;
              cnt_r     <= {CNT_W{1'b0}};
              cic_rst_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_SETTLE: begin
            if (stb_d_r) begin
              if (cnt_r == CNT_W'(SETTLE_N - 1)) begin
                state_r  <= ST_RUN;
                cnt_r    <= {CNT_W{1'b0}};
                locked_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          ST_RUN: begin
            if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
              drop_cnt_r <= drop_cnt_r + DROP_W'(1);
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            cic_rst_r <= 1'b1;
            locked_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_lia_sequencer.sv
// Directed bench: a 2-stage, R=16 CIC decimator (gain normalised by >>8) drives
// the sequencer; a DROP_W=4 instance with m_ready tied low covers saturation.
module tb_cic_lia_sequencer;

  localparam int DATA_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              restart;
  logic              m_ready;
  logic              cic_rst;
  logic              cic_dclk;
  logic [DATA_W-1:0] cic_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              locked;
  logic [1:0]        state;
  logic [15:0]       drop_cnt;

  logic              cic_rst4;
  logic [DATA_W-1:0] m_data4;
  logic              m_valid4;
  logic              locked4;
  logic [1:0]        state4;
  logic [3:0]        drop_cnt4;

  logic signed [15:0] cic_x;
  logic [3:0]         dcnt;
  logic signed [39:0] i1, i2, c1_d, c2_d, c1_s, out_s;

  int unsigned cyc = 0;
  int unsigned last_dclk = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cic_lia_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .cic_rst(cic_rst), .cic_dclk(cic_dclk), .cic_data(cic_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .locked(locked), .state(state), .drop_cnt(drop_cnt)
  );

  cic_lia_sequencer #(.DROP_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .restart(1'b0),
    .cic_rst(cic_rst4), .cic_dclk(cic_dclk), .cic_data(cic_data),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(1'b0),
    .locked(locked4), .state(state4), .drop_cnt(drop_cnt4)
  );

  // CIC decimator, N=2, R=16, output scaled by 1/256 so DC gain is one
  assign cic_dclk = (dcnt == 4'd15) && !cic_rst;
  assign c1_s     = i2 - c1_d;
  assign out_s    = c1_s - c2_d;

  always_ff @(posedge clk) begin
    if (cic_rst) begin
      i1 <= 40'sd0; i2 <= 40'sd0; c1_d <= 40'sd0; c2_d <= 40'sd0;
      dcnt <= 4'd0; cic_data <= 14'd0;
    end else begin
      i1   <= i1 + {{24{cic_x[15]}}, cic_x};
      i2   <= i2 + i1;
      dcnt <= dcnt + 4'd1;
      if (cic_dclk) begin
        c1_d     <= i2;
        c2_d     <= c1_s;
        cic_data <= out_s[21:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cic_dclk) last_dclk <= cyc;
    cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n_rst, n_dclk, g, n_cap, bad;
    logic seen;
    logic [DATA_W-1:0] exp_neg;
    exp_neg = 14'h3E0C;
    rst = 1'b1; enable = 1'b0; restart = 1'b0; m_ready = 1'b1; cic_x = 16'sd1000;
    repeat (3) @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_cic_rst", cic_rst, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_eq("idle_restart_ignored", state, 0);

    // Test 1: start-up, reset length, settle discards
    enable = 1'b1;
    n_rst = 0;
    for (int i = 0; i < 12 && state != 2'd2; i++) begin
      @(negedge clk);
      if (state == 2'd1 && cic_rst) n_rst++;
    end
    check_eq("t1_rst_cycles", n_rst, 4);
    check_eq("t1_settle_state", state, 2);
    check_eq("t1_cic_rst_low", cic_rst, 0);
    n_dclk = 0;
    for (int i = 0; i < 200 && !m_valid; i++) begin
      if (cic_dclk) n_dclk++;
      @(negedge clk);
    end
    check_eq("t1_first_sample_idx", n_dclk, 4);
    check_eq("t1_valid", m_valid, 1);
    check_eq("t1_data", m_data, 1000);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_state", state, 3);
    check_eq("t1_latency", cyc - last_dclk, 2);

    // Test 2: one-clock valid pulse every 16 clocks, 2 clocks after strobe
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      check_eq("t2_pulse_width", m_valid, 0);
      g = 1;
      while (!m_valid && g < 40) begin
        @(negedge clk);
        g++;
      end
      check_eq("t2_period", g, 16);
      check_eq("t2_latency", cyc - last_dclk, 2);
      check_eq("t2_data", m_data, 1000);
    end
    @(negedge clk);

    // Test 3: 50 clocks of back-pressure
    check_eq("t3_start_idle", m_valid, 0);
    m_ready = 1'b0;
    n_cap = 0; bad = 0; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (seen && (!m_valid || m_data != 14'd1000)) bad++;
      if (m_valid) seen = 1'b1;
      if (i <= 48 && cic_dclk) n_cap++;
      @(negedge clk);
    end
    check_eq("t3_hold_stable", bad, 0);
    check_eq("t3_drop_cnt", drop_cnt, n_cap - 1);
    check_eq("t3_valid_held", m_valid, 1);
    check_eq("t3_data_held", m_data, 1000);
    m_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_handshake", m_valid, 0);
    repeat (40) @(negedge clk);
    check_eq("t3_drop_frozen", drop_cnt, n_cap - 1);

    // Test 4: 4-bit drop counter saturation
    for (int i = 0; i < 600 && drop_cnt4 != 4'd15; i++) @(negedge clk);
    check_eq("t4_drop_reach", drop_cnt4, 15);
    check_eq("t4_state4", state4, 3);
    repeat (80) @(negedge clk);
    check_eq("t4_drop_sat", drop_cnt4, 15);
    check_eq("t4_locked4", locked4, 1);

    // Test 5: restart in RUN with a pending sample
    m_ready = 1'b0;
    for (int i = 0; i < 40 && !m_valid; i++) @(negedge clk);
    check_eq("t5_pending", m_valid, 1);
    restart = 1'b1;
    cic_x = -16'sd500;
    @(negedge clk);
    restart = 1'b0;
    m_ready = 1'b1;
    check_eq("t5_valid_clr", m_valid, 0);
    check_eq("t5_state", state, 1);
    check_eq("t5_drop_clr", drop_cnt, 0);
    check_eq("t5_cic_rst", cic_rst, 1);
    check_eq("t5_unlocked", locked, 0);
    for (int i = 0; i < 12 && state != 2'd2; i++) @(negedge clk);
    n_dclk = 0;
    for (int i = 0; i < 200 && !m_valid; i++) begin
      if (cic_dclk) n_dclk++;
      @(negedge clk);
    end
    check_eq("t5_resettle_idx", n_dclk, 4);
    check_eq("t5_data_neg", m_data, exp_neg);
    check_eq("t5_locked", locked, 1);

    // Test 6: enable fall beats restart, then async reset mid-SETTLE
    @(negedge clk);
    enable = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_eq("t6_idle", state, 0);
    check_eq("t6_cic_rst", cic_rst, 1);
    check_eq("t6_valid", m_valid, 0);
    check_eq("t6_locked", locked, 0);
    enable = 1'b1;
    for (int i = 0; i < 12 && state != 2'd2; i++) @(negedge clk);
    check_eq("t6_settle", state, 2);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_arst_state", state, 0);
    check_eq("t6_arst_cic_rst", cic_rst, 1);
    check_eq("t6_arst_valid", m_valid, 0);
    check_eq("t6_arst_data", m_data, 0);
    check_eq("t6_arst_locked", locked, 0);
    check_eq("t6_arst_drop", drop_cnt, 0);
    check_eq("t6_arst_drop4", drop_cnt4, 0);
    check_eq("t6_arst_data4", m_data4, 0);
    check_eq("t6_arst_valid4", m_valid4, 0);
    check_eq("t6_arst_cic_rst4", cic_rst4, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
